// File: rtl/usb_fs_rx.sv
// -----------------------------------------------------------------------------
// usb_fs_rx
// USB full-speed receive front end. Oversamples the D+/D- pins at 48 MHz
// (four clocks per 12 Mbit/s bit), recovers bit timing from line transitions,
// NRZI-decodes, hunts for SYNC, strips stuffed bits and assembles bytes
// LSB-first. Emits a byte stream with start/end/error strobes and a bus reset
// level for the packet buffer writer.
//
// Ports:
//   clock48      in   48 MHz system clock
//   reset_n      in   asynchronous active-low reset
//   usb_dp       in   raw D+ pin
//   usb_dn       in   raw D- pin
//   byte_data    out  [7:0] received byte, bit 0 = first bit on the wire
//   byte_valid   out  one-cycle strobe, byte_data valid this cycle
//   packet_start out  one-cycle strobe on SYNC detection
//   packet_end   out  one-cycle strobe on valid EOP (SE0 then J)
//   packet_error out  one-cycle strobe on stuff, alignment or EOP error
//   bus_reset    out  level, high while SE0 has lasted RESET_CYCLES or more
// -----------------------------------------------------------------------------
module usb_fs_rx #(
    parameter int RESET_CYCLES   = 120,
    parameter int SYNC_MIN_ZEROS = 5
) (
    input  logic       clock48,
    input  logic       reset_n,
    input  logic       usb_dp,
    input  logic       usb_dn,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       packet_start,
    output logic       packet_end,
    output logic       packet_error,
    output logic       bus_reset
);

    localparam int               SE0_W      = $clog2(RESET_CYCLES + 1);
    localparam logic [SE0_W-1:0] SE0_LIMIT  = SE0_W'(RESET_CYCLES);
    localparam logic [2:0]       SYNC_ZEROS = 3'(SYNC_MIN_ZEROS);

    // Line encodings as {dp, dn}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_SE1 = 2'b11;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        EOP,
        DISCARD
    } state_t;

    logic             dp_meta, dp_sync, dn_meta, dn_sync;
    logic [1:0]       line, line_q;
    logic [1:0]       phase, phase_eff;
    logic             sample_pt;
    logic             is_se0, is_se1, is_j;
    logic             bit_val;
    logic [7:0]       shifted;

    state_t           state, state_next;
    logic [2:0]       zero_cnt, zero_cnt_next;
    logic [2:0]       ones_cnt, ones_cnt_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift_reg, shift_reg_next;
    logic             saw_se0, saw_se0_next;
    logic             prev_j, prev_j_next;
    logic [SE0_W-1:0] se0_cnt, se0_cnt_next;

    logic [7:0]       byte_data_next;
    logic             byte_valid_next, packet_start_next, packet_end_next;
    logic             packet_error_next, bus_reset_next;

    // Two-flop synchronisers. They reset to J so the idle bus does not look
    // like a transition or a short SE0 right after reset.
    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dn_meta <= 1'b0;
            dn_sync <= 1'b0;
        end else begin
            dp_meta <= usb_dp;
            dp_sync <= dp_meta;
            dn_meta <= usb_dn;
            dn_sync <= dn_meta;
        end
    end

    assign line   = {dp_sync, dn_sync};
    assign is_se0 = (line == LINE_SE0);
    assign is_se1 = (line == LINE_SE1);
    assign is_j   = (line == LINE_J);

    // The phase reads as 0 on the very cycle the line changes, so the sample
    // point lands two cycles into each bit, which keeps 3- and 5-cycle bits
    // safe.
    assign phase_eff = (line != line_q) ? 2'd0 : phase;
    assign sample_pt = (phase_eff == 2'd2);

    // NRZI: no level change means a 1. SE1 counts as K here.
    assign bit_val = (is_j == prev_j);
    assign shifted = {bit_val, shift_reg[7:1]};

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= LINE_J;
            phase  <= 2'd0;
        end else begin
            line_q <= line;
            phase  <= phase_eff + 2'd1;
        end
    end

    // Receiver state and all registered outputs.
    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= HUNT;
            zero_cnt     <= 3'd0;
            ones_cnt     <= 3'd0;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'd0;
            saw_se0      <= 1'b0;
            prev_j       <= 1'b1;
            se0_cnt      <= '0;
            byte_data    <= 8'd0;
            byte_valid   <= 1'b0;
            packet_start <= 1'b0;
            packet_end   <= 1'b0;
            packet_error <= 1'b0;
            bus_reset    <= 1'b0;
        end else begin
            state        <= state_next;
            zero_cnt     <= zero_cnt_next;
            ones_cnt     <= ones_cnt_next;
            bit_cnt      <= bit_cnt_next;
            shift_reg    <= shift_reg_next;
            saw_se0      <= saw_se0_next;
            prev_j       <= prev_j_next;
            se0_cnt      <= se0_cnt_next;
            byte_data    <= byte_data_next;
            byte_valid   <= byte_valid_next;
            packet_start <= packet_start_next;
            packet_end   <= packet_end_next;
            packet_error <= packet_error_next;
            bus_reset    <= bus_reset_next;
        end
    end

    // Next-state and strobe logic. Bit-level work only happens on sample
    // points; bus reset overrides everything and silences the strobes.
    always_comb begin
        state_next        = state;
        zero_cnt_next     = zero_cnt;
        ones_cnt_next     = ones_cnt;
        bit_cnt_next      = bit_cnt;
        shift_reg_next    = shift_reg;
        saw_se0_next      = saw_se0;
        prev_j_next       = prev_j;
        byte_data_next    = byte_data;
        byte_valid_next   = 1'b0;
        packet_start_next = 1'b0;
        packet_end_next   = 1'b0;
        packet_error_next = 1'b0;

        if (!is_se0) begin
            se0_cnt_next = '0;
        end else if (se0_cnt != SE0_LIMIT) begin
            se0_cnt_next = se0_cnt + 1'b1;
        end else begin
            se0_cnt_next = se0_cnt;
        end
        bus_reset_next = (se0_cnt_next == SE0_LIMIT);

        if (bus_reset) begin
            state_next    = HUNT;
            zero_cnt_next = 3'd0;
            ones_cnt_next = 3'd0;
            bit_cnt_next  = 3'd0;
            saw_se0_next  = 1'b0;
        end else if (sample_pt) begin
            if (!is_se0) begin
                prev_j_next = is_j;
            end

            case (state)
                HUNT: begin
                    if (is_se0) begin
                        zero_cnt_next = 3'd0;
                    end else if (!bit_val) begin
                        zero_cnt_next = (zero_cnt == 3'd7) ? 3'd7 : zero_cnt + 3'd1;
                    end else if (zero_cnt >= SYNC_ZEROS) begin
                        state_next        = DATA;
                        packet_start_next = 1'b1;
                        zero_cnt_next     = 3'd0;
                        ones_cnt_next     = 3'd0;
                        bit_cnt_next      = 3'd0;
                    end else begin
                        zero_cnt_next = 3'd0;
                    end
                end

                DATA: begin
                    if (is_se0) begin
                        state_next = EOP;
                    end else if (is_se1) begin
                        packet_error_next = 1'b1;
                        state_next        = DISCARD;
                        saw_se0_next      = 1'b0;
                    end else if (ones_cnt == 3'd6) begin
                        // This bit must be a stuffed 0; it is never data.
                        if (bit_val) begin
                            packet_error_next = 1'b1;
                            state_next        = DISCARD;
                            saw_se0_next      = 1'b0;
                        end else begin
                            ones_cnt_next = 3'd0;
                        end
                    end else begin
                        ones_cnt_next  = bit_val ? ones_cnt + 3'd1 : 3'd0;
                        shift_reg_next = shifted;
                        bit_cnt_next   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_data_next  = shifted;
                            byte_valid_next = 1'b1;
                        end
                    end
                end

                EOP: begin
                    if (is_j) begin
                        packet_end_next   = 1'b1;
                        packet_error_next = (bit_cnt != 3'd0);
                        state_next        = HUNT;
                        zero_cnt_next     = 3'd0;
                    end else if (!is_se0) begin
                        packet_error_next = 1'b1;
                        state_next        = DISCARD;
                        saw_se0_next      = 1'b0;
                    end
                end

                DISCARD: begin
                    // Leave only on an SE0 sample directly followed by J.
                    if (is_se0) begin
                        saw_se0_next = 1'b1;
                    end else begin
                        saw_se0_next = 1'b0;
                        if (is_j && saw_se0) begin
                            state_next    = HUNT;
                            zero_cnt_next = 3'd0;
                        end
                    end
                end

                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fs_rx.sv
// -----------------------------------------------------------------------------
// tb_usb_fs_rx
// Drives NRZI-encoded, bit-stuffed USB full-speed packets onto the pins and
// checks the receiver against a packet-level model: each packet pushes the
// strobe events it must produce (start, each byte, end / end+error) into a
// queue, and a per-cycle checker pops them as the DUT strobes. Bus reset is
// predicted from the run length of SE0 on the pins plus the two-flop
// synchroniser delay.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_fs_rx;

   localparam int RESET_CYCLES = 120;

   localparam int EV_START  = 256;
   localparam int EV_BYTE   = 512;
   localparam int EV_END    = 768;
   localparam int EV_ENDERR = 1024;
   localparam int EV_ERR    = 1280;

   logic       clock48 = 1'b0;
   logic       reset_n = 1'b0;
   logic       usb_dp  = 1'b1;
   logic       usb_dn  = 1'b0;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       packet_start;
   logic       packet_end;
   logic       packet_error;
   logic       bus_reset;

   int         total = 0;
   int         bad   = 0;

   int         exp_q[$];
   logic [7:0] exp_last_byte = 8'd0;
   logic [7:0] obs_bytes[$];
   int         n_start, n_byte, n_end, n_err, n_enderr, br_cycles;

   int         pin_run, run_d1, run_d2;
   logic       exp_bus = 1'b0;

   logic       cur_j = 1'b1;
   int         tx_ones = 0;
   int         jitter_mode = 0;
   bit         alt = 1'b0;
   int         stuff_count = 0;
   logic [7:0] pkt_bytes [8];

   usb_fs_rx #(
      .RESET_CYCLES  (RESET_CYCLES),
      .SYNC_MIN_ZEROS(5)
   ) dut (
      .clock48     (clock48),
      .reset_n     (reset_n),
      .usb_dp      (usb_dp),
      .usb_dn      (usb_dn),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .packet_start(packet_start),
      .packet_end  (packet_end),
      .packet_error(packet_error),
      .bus_reset   (bus_reset)
   );

   // 20 ns period stands in for the 48 MHz clock
   always #10 clock48 = ~clock48;

   // Global time limit so the bench always ends on its own
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic expectEq(input string name, input int actual, input int required);
      total++;
      if (actual != required) begin
         bad++;
         $display("[TB] FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                  name, actual, actual, required, required, $time);
      end
   endtask

   // Bus reset model: SE0 run length of the pins, seen two clocks late
   // through the synchroniser; high once that run reaches RESET_CYCLES.
   always @(posedge clock48 or negedge reset_n) begin
      if (!reset_n) begin
         pin_run = 0;
         run_d1  = 0;
         run_d2  = 0;
         exp_bus = 1'b0;
      end else begin
         exp_bus = (run_d2 >= RESET_CYCLES);
         run_d2  = run_d1;
         pin_run = ({usb_dp, usb_dn} == 2'b00) ? pin_run + 1 : 0;
         run_d1  = pin_run;
      end
   end

   // Per-cycle compare of every output against the model
   task automatic checkOutput();
      int   obs;
      int   e;
      logic combo_bad;
      if (!reset_n) begin
         expectEq("reset_outputs",
                  int'({byte_data, byte_valid, packet_start, packet_end, packet_error, bus_reset}), 0);
         exp_q.delete();
         exp_last_byte = 8'd0;
         return;
      end
      expectEq("bus_reset", int'(bus_reset), int'(exp_bus));
      if (bus_reset) br_cycles++;
      if (byte_valid || packet_start || packet_end || packet_error) begin
         combo_bad = ((int'(byte_valid) + int'(packet_start) + int'(packet_end)) > 1) ||
                     (packet_error && (byte_valid || packet_start));
         expectEq("strobe_exclusive", int'(combo_bad), 0);
         if (packet_start) begin
            obs = EV_START;
            n_start++;
         end else if (byte_valid) begin
            obs = EV_BYTE + int'(byte_data);
            n_byte++;
            obs_bytes.push_back(byte_data);
         end else if (packet_end && packet_error) begin
            obs = EV_ENDERR;
            n_end++;
            n_err++;
            n_enderr++;
         end else if (packet_end) begin
            obs = EV_END;
            n_end++;
         end else begin
            obs = EV_ERR;
            n_err++;
         end
         if (exp_q.size() == 0) begin
            expectEq("unexpected_strobe", obs, 0);
         end else begin
            e = exp_q.pop_front();
            expectEq("strobe_event", obs, e);
            if (e >= EV_BYTE && e < EV_END) exp_last_byte = e[7:0];
         end
      end
      expectEq("byte_data_hold", int'(byte_data), int'(exp_last_byte));
   endtask

   always @(negedge clock48) checkOutput();

   task automatic clearCounts();
      n_start   = 0;
      n_byte    = 0;
      n_end     = 0;
      n_err     = 0;
      n_enderr  = 0;
      br_cycles = 0;
      obs_bytes.delete();
      stuff_count = 0;
   endtask

   task automatic checkDrained(input string name);
      expectEq(name, exp_q.size(), 0);
   endtask

   function automatic int bitPeriod();
      if (jitter_mode == 0) return 4;
      alt = !alt;
      return alt ? 3 : 5;
   endfunction

   task automatic driveLine(input logic [1:0] l, input int cycles);
      {usb_dp, usb_dn} = l;
      repeat (cycles) @(negedge clock48);
   endtask

   task automatic sendLevel(input logic j);
      driveLine(j ? 2'b10 : 2'b01, bitPeriod());
   endtask

   task automatic sendIdle(input int bits);
      cur_j = 1'b1;
      repeat (bits) sendLevel(1'b1);
   endtask

   // KJKJKJKK
   task automatic sendSync();
      for (int i = 0; i < 8; i++) begin
         sendLevel((i < 7) ? (i % 2 == 1) : 1'b0);
      end
      cur_j   = 1'b0;
      tx_ones = 0;
   endtask

   // NRZI-encode one data bit, inserting a stuffed 0 after six 1s
   task automatic sendBit(input logic b);
      if (!b) cur_j = !cur_j;
      sendLevel(cur_j);
      tx_ones = b ? tx_ones + 1 : 0;
      if (tx_ones == 6) begin
         cur_j = !cur_j;
         sendLevel(cur_j);
         tx_ones = 0;
         stuff_count++;
      end
   endtask

   task automatic sendEop();
      driveLine(2'b00, bitPeriod());
      driveLine(2'b00, bitPeriod());
      tx_ones = 0;
      sendIdle(8);
   endtask

   // Pushes the events the packet must produce, then drives it
   task automatic applyStimulus(input int nbytes, input int extra_bits, input logic [7:0] extra_val);
      exp_q.push_back(EV_START);
      for (int i = 0; i < nbytes; i++) exp_q.push_back(EV_BYTE + int'(pkt_bytes[i]));
      exp_q.push_back((extra_bits == 0) ? EV_END : EV_ENDERR);
      sendSync();
      for (int i = 0; i < nbytes; i++) begin
         for (int k = 0; k < 8; k++) sendBit(pkt_bytes[i][k]);
      end
      for (int k = 0; k < extra_bits; k++) sendBit(extra_val[k]);
      sendEop();
   endtask

   initial begin
      int nb;
      int extra;
      clearCounts();
      {usb_dp, usb_dn} = 2'b10;
      repeat (5) @(negedge clock48);
      #2 reset_n = 1'b1;
      @(negedge clock48);
      sendIdle(10);

      // Reset asserted in the middle of a packet
      $display("[TB] reset mid-packet");
      jitter_mode = 0;
      exp_q.push_back(EV_START);
      sendSync();
      for (int k = 0; k < 5; k++) sendBit(k[0]);
      #2 reset_n = 1'b0;
      {usb_dp, usb_dn} = 2'b10;
      repeat (10) @(negedge clock48);
      #2 reset_n = 1'b1;
      cur_j   = 1'b1;
      tx_ones = 0;
      clearCounts();
      @(negedge clock48);
      driveLine(2'b10, 200);
      expectEq("reset_no_start", n_start, 0);
      expectEq("reset_no_byte", n_byte, 0);
      expectEq("reset_no_end_err", n_end + n_err, 0);
      checkDrained("reset_drained");

      // Basic packet
      $display("[TB] basic packet 0xA5");
      clearCounts();
      pkt_bytes[0] = 8'hA5;
      applyStimulus(1, 0, 8'h00);
      expectEq("basic_start", n_start, 1);
      expectEq("basic_bytes", n_byte, 1);
      expectEq("basic_value", int'(obs_bytes[0]), 8'hA5);
      expectEq("basic_end", n_end, 1);
      expectEq("basic_err", n_err, 0);
      checkDrained("basic_drained");

      // Bit stuffing
      $display("[TB] stuffing 0xFF 0x00");
      clearCounts();
      pkt_bytes[0] = 8'hFF;
      pkt_bytes[1] = 8'h00;
      applyStimulus(2, 0, 8'h00);
      expectEq("stuff_inserted", stuff_count, 1);
      expectEq("stuff_bytes", n_byte, 2);
      expectEq("stuff_first", int'(obs_bytes[0]), 8'hFF);
      expectEq("stuff_second", int'(obs_bytes[1]), 8'h00);
      expectEq("stuff_err", n_err, 0);
      checkDrained("stuff_drained");

      // Stuff error: seven 1s without a stuffed bit
      $display("[TB] stuff error");
      clearCounts();
      exp_q.push_back(EV_START);
      exp_q.push_back(EV_ERR);
      sendSync();
      repeat (7) sendLevel(cur_j);
      sendEop();
      expectEq("stufferr_err", n_err, 1);
      expectEq("stufferr_bytes", n_byte, 0);
      expectEq("stufferr_end", n_end, 0);
      checkDrained("stufferr_drained");
      clearCounts();
      pkt_bytes[0] = 8'hC3;
      applyStimulus(1, 0, 8'h00);
      expectEq("after_stufferr_value", int'(obs_bytes[0]), 8'hC3);
      expectEq("after_stufferr_end", n_end, 1);
      checkDrained("after_stufferr_drained");

      // Alignment error with 3/5 cycle jitter
      $display("[TB] alignment with jitter");
      clearCounts();
      jitter_mode = 1;
      pkt_bytes[0] = 8'h3C;
      applyStimulus(1, 4, 8'h0A);
      expectEq("align_value", int'(obs_bytes[0]), 8'h3C);
      expectEq("align_end_err_same_cycle", n_enderr, 1);
      expectEq("align_err_total", n_err, 1);
      checkDrained("align_drained");

      // Bus reset in the middle of a packet
      $display("[TB] bus reset mid-packet");
      clearCounts();
      jitter_mode = 0;
      exp_q.push_back(EV_START);
      exp_q.push_back(EV_BYTE + 8'h81);
      sendSync();
      for (int k = 0; k < 8; k++) sendBit(k == 0 || k == 7);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      driveLine(2'b00, 130);
      cur_j = 1'b1;
      driveLine(2'b10, 40);
      expectEq("busreset_cycles", br_cycles, 11);
      expectEq("busreset_end", n_end, 0);
      expectEq("busreset_err", n_err, 0);
      checkDrained("busreset_drained");
      clearCounts();
      pkt_bytes[0] = 8'h5A;
      applyStimulus(1, 0, 8'h00);
      expectEq("after_busreset_value", int'(obs_bytes[0]), 8'h5A);
      expectEq("after_busreset_end", n_end, 1);
      checkDrained("after_busreset_drained");

      // Randomized packets
      $display("[TB] random packets");
      for (int p = 0; p < 25; p++) begin
         jitter_mode = int'($urandom_range(0, 1));
         nb = int'($urandom_range(1, 4));
         for (int i = 0; i < nb; i++) pkt_bytes[i] = 8'($urandom);
         extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
         applyStimulus(nb, extra, 8'($urandom));
         sendIdle(int'($urandom_range(2, 10)));
         checkDrained("random_drained");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
